// File: rtl/fpuv_op_sequencer.sv
`default_nettype none
// ============================================================================
// fpuv_op_sequencer: fetches operand tuples, issues them to the FPU, logs
// {flags, result} and issue-to-result latency. Revision 1.0 - initial release
// ============================================================================
module fpuv_op_sequencer #(
    parameter int ELEN            = 64,
    parameter int NUM_SRCS        = 3,
    parameter int ADDR_W          = 12,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLAGS_W         = 5,
    parameter int TIMEOUT         = 1024,
    parameter int LAT_W           = 16
) (
    input  logic                      clk_i,
    input  logic                      rsn_i,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [ADDR_W-1:0]         num_ops_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic                      spurious_o,
    output logic                      vec_rd_o,
    output logic [ADDR_W-1:0]         vec_addr_o,
    input  logic [ELEN-1:0]           vec_rdata_i,
    output logic [NUM_SRCS*ELEN-1:0]  op_src_o,
    output logic                      op_valid_o,
    input  logic                      op_ready_i,
    input  logic [ELEN-1:0]           result_data_i,
    input  logic [FLAGS_W-1:0]        result_flags_i,
    input  logic                      result_valid_i,
    output logic                      res_we_o,
    output logic [ADDR_W-1:0]         res_addr_o,
    output logic [FLAGS_W+ELEN-1:0]   res_wdata_o,
    output logic [ADDR_W-1:0]         issued_o,
    output logic [ADDR_W-1:0]         retired_o,
    output logic [LAT_W-1:0]          max_lat_o,
    output logic [LAT_W-1:0]          min_lat_o
);
    localparam int IDX_W = $clog2(NUM_SRCS + 1);
    localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic                       mode_q, mode_d;
    logic [ADDR_W-1:0]          num_ops_q, num_ops_d;
    logic [ADDR_W-1:0]          issued_q, issued_d;
    logic [ADDR_W-1:0]          retired_q, retired_d;
    logic [OST_W-1:0]           outst_q, outst_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LAT_W-1:0]           cyc_q;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic [IDX_W-1:0]           fetch_idx_q, fetch_idx_d;
    logic                       cap_valid_q, cap_valid_d;
    logic [IDX_W-1:0]           cap_idx_q, cap_idx_d;
    logic [NUM_SRCS*ELEN-1:0]   src_q, src_d;
    logic                       spurious_q, spurious_d;
    logic [LAT_W-1:0]           max_lat_q, max_lat_d;
    logic [LAT_W-1:0]           min_lat_q, min_lat_d;
    logic [LAT_W-1:0]           ts_fifo_q [MAX_OUTSTANDING];

    logic                       w_active, w_res_acc, w_hs, w_credit, w_rd, w_stuck;
    logic [LAT_W-1:0]           w_lat;
    logic [ADDR_W-1:0]          w_issued_inc, w_rd_addr;

    assign w_active     = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign w_res_acc    = result_valid_i && w_active && (outst_q != '0);
    assign w_hs         = (state_q == S_ISSUE) && op_ready_i;
    assign w_credit     = mode_q ? (outst_q < OST_W'(MAX_OUTSTANDING)) : (outst_q == '0);
    // Credit is only checked before the first read of a tuple; nothing can consume it mid-fetch.
    assign w_rd         = (state_q == S_FETCH) && (fetch_idx_q < IDX_W'(NUM_SRCS))
                          && ((fetch_idx_q != '0) || w_credit);
    assign w_rd_addr    = (issued_q * ADDR_W'(NUM_SRCS)) + ADDR_W'(fetch_idx_q);
    assign w_issued_inc = issued_q + ADDR_W'(1);
    assign w_lat        = cyc_q - ts_fifo_q[rd_ptr_q];
    assign w_stuck      = w_active && (outst_q != '0) && !w_res_acc;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        num_ops_d   = num_ops_q;
        issued_d    = issued_q;
        retired_d   = retired_q;
        outst_d     = outst_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tmo_d       = w_stuck ? (tmo_q + TMO_W'(1)) : '0;
        fetch_idx_d = fetch_idx_q;
        cap_valid_d = w_rd;
        cap_idx_d   = cap_idx_q;
        src_d       = src_q;
        spurious_d  = spurious_q;
        max_lat_d   = max_lat_q;
        min_lat_d   = min_lat_q;

        if (w_hs) begin
            issued_d = w_issued_inc;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_res_acc) begin
            retired_d = retired_q + ADDR_W'(1);
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            if (w_lat > max_lat_q) max_lat_d = w_lat;
            if (w_lat < min_lat_q) min_lat_d = w_lat;
        end
        if (w_hs && !w_res_acc) begin
            outst_d = outst_q + OST_W'(1);
        end else if (!w_hs && w_res_acc) begin
            outst_d = outst_q - OST_W'(1);
        end
        if (result_valid_i && (outst_q == '0)) spurious_d = 1'b1;

        if (w_rd) begin
            fetch_idx_d = fetch_idx_q + IDX_W'(1);
            cap_idx_d   = fetch_idx_q;
        end
        if (cap_valid_q) src_d[int'(cap_idx_q)*ELEN +: ELEN] = vec_rdata_i;

        case (state_q)
            S_FETCH: begin
                if (cap_valid_q && (cap_idx_q == IDX_W'(NUM_SRCS - 1))) begin
                    state_d     = S_ISSUE;
                    fetch_idx_d = '0;
                end
            end
            S_ISSUE: begin
                if (w_hs) state_d = (w_issued_inc < num_ops_q) ? S_FETCH : S_DRAIN;
            end
            S_DRAIN: begin
                if (retired_q == num_ops_q) state_d = S_DONE;
            end
            default: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    num_ops_d   = num_ops_i;
                    issued_d    = '0;
                    retired_d   = '0;
                    outst_d     = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    tmo_d       = '0;
                    fetch_idx_d = '0;
                    spurious_d  = 1'b0;
                    max_lat_d   = '0;
                    min_lat_d   = '1;
                    state_d     = (num_ops_i == '0) ? S_DONE : S_FETCH;
                end
            end
        endcase

        if (w_stuck && (tmo_q == TMO_W'(TIMEOUT - 1))) state_d = S_ERR;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            num_ops_q   <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cyc_q       <= '0;
            tmo_q       <= '0;
            fetch_idx_q <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            src_q       <= '0;
            spurious_q  <= 1'b0;
            max_lat_q   <= '0;
            min_lat_q   <= '1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            num_ops_q   <= num_ops_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            outst_q     <= outst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cyc_q       <= cyc_q + LAT_W'(1);
            tmo_q       <= tmo_d;
            fetch_idx_q <= fetch_idx_d;
            cap_valid_q <= cap_valid_d;
            cap_idx_q   <= cap_idx_d;
            src_q       <= src_d;
            spurious_q  <= spurious_d;
            max_lat_q   <= max_lat_d;
            min_lat_q   <= min_lat_d;
        end
    end

    // Timestamp storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_hs) ts_fifo_q[wr_ptr_q] <= cyc_q;
    end

    assign busy_o      = w_active;
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign timeout_o   = (state_q == S_ERR);
    assign spurious_o  = spurious_q;
    assign vec_rd_o    = w_rd;
    assign vec_addr_o  = w_rd ? w_rd_addr : '0;
    assign op_src_o    = src_q;
    assign op_valid_o  = (state_q == S_ISSUE);
    assign res_we_o    = w_res_acc;
    assign res_addr_o  = retired_q;
    assign res_wdata_o = w_res_acc ? {result_flags_i, result_data_i} : '0;
    assign issued_o    = issued_q;
    assign retired_o   = retired_q;
    assign max_lat_o   = max_lat_q;
    assign min_lat_o   = min_lat_q;

endmodule
`default_nettype wire

// File: tb/tb_fpuv_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fpuv_op_sequencer: vector table + random FPU model bench for the sequencer.
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fpuv_op_sequencer;
    localparam int ELEN = 64;
    localparam int NS   = 3;
    localparam int AW   = 12;
    localparam int MO   = 4;
    localparam int FW   = 5;
    localparam int TMO  = 1024;
    localparam int LW   = 16;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #5 clk = ~clk;

    logic                 start = 1'b0, mode = 1'b0;
    logic [AW-1:0]        num_ops = '0;
    logic                 busy, done, tmo_flag, spurious, vec_rd, op_valid, res_we;
    logic [AW-1:0]        vec_addr, res_addr, issued, retired;
    logic [ELEN-1:0]      vec_rdata = '0;
    logic [NS*ELEN-1:0]   op_src;
    logic                 op_ready;
    logic [ELEN-1:0]      res_data;
    logic [FW-1:0]        res_flags;
    logic                 res_valid, mdl_valid;
    logic                 spur = 1'b0;
    logic [FW+ELEN-1:0]   res_wdata;
    logic [LW-1:0]        max_lat, min_lat;

    assign res_valid = mdl_valid | spur;

    fpuv_op_sequencer #(
        .ELEN(ELEN), .NUM_SRCS(NS), .ADDR_W(AW), .MAX_OUTSTANDING(MO),
        .FLAGS_W(FW), .TIMEOUT(TMO), .LAT_W(LW)
    ) dut (
        .clk_i(clk), .rsn_i(rsn), .start_i(start), .mode_i(mode), .num_ops_i(num_ops),
        .busy_o(busy), .done_o(done), .timeout_o(tmo_flag), .spurious_o(spurious),
        .vec_rd_o(vec_rd), .vec_addr_o(vec_addr), .vec_rdata_i(vec_rdata),
        .op_src_o(op_src), .op_valid_o(op_valid), .op_ready_i(op_ready),
        .result_data_i(res_data), .result_flags_i(res_flags), .result_valid_i(res_valid),
        .res_we_o(res_we), .res_addr_o(res_addr), .res_wdata_o(res_wdata),
        .issued_o(issued), .retired_o(retired), .max_lat_o(max_lat), .min_lat_o(min_lat)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Vector memory with one-cycle read latency
    logic [ELEN-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (vec_rd) vec_rdata <= mem[vec_addr];

    function automatic logic [FW+ELEN-1:0] fpu_fn(input logic [ELEN-1:0] a, b, c);
        logic [ELEN-1:0] r;
        r = (a * 64'd3) + (b ^ c);
        return {a[4:0] ^ c[4:0] ^ b[9:5], r};
    endfunction

    function automatic logic [FW+ELEN-1:0] expect_op(input int i);
        return fpu_fn(mem[(i*NS) % (1<<AW)], mem[(i*NS+1) % (1<<AW)], mem[(i*NS+2) % (1<<AW)]);
    endfunction

    // FPU model: in-order results, each due a chosen latency after its accepting cycle
    typedef struct { longint due; logic [FW+ELEN-1:0] res; } pend_t;
    pend_t  pq[$];
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     rdy_mode = 0, fpu_lat = 4, run_hs = 0, run_wr = 0, lat_now = 0;
    int     mdl_min = 65535, mdl_max = 0;
    bit     lat_rand = 1'b0, fpu_mute = 1'b0;
    longint last_due = 0, due_now = 0, last_evt = 0;

    always @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            pq.delete();
            mdl_valid <= 1'b0;
            op_ready  <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
        end else begin
            if (op_valid && op_ready) begin
                lat_now = lat_rand ? int'($urandom_range(1, 15)) : fpu_lat;
                due_now = cyc + longint'(lat_now);
                if (due_now <= last_due) due_now = last_due + 1;
                last_due = due_now;
                if (int'(due_now - cyc) > mdl_max) mdl_max = int'(due_now - cyc);
                if (int'(due_now - cyc) < mdl_min) mdl_min = int'(due_now - cyc);
                pq.push_back('{due_now, fpu_fn(op_src[0 +: ELEN], op_src[ELEN +: ELEN],
                                               op_src[2*ELEN +: ELEN])});
                run_hs++;
                last_evt = cyc;
            end
            if (!fpu_mute && (pq.size() > 0) && (pq[0].due <= cyc + 1)) begin
                mdl_valid <= 1'b1;
                {res_flags, res_data} <= pq[0].res;
                void'(pq.pop_front());
            end else begin
                mdl_valid <= 1'b0;
            end
            case (rdy_mode)
                0:       op_ready <= 1'b1;
                1:       op_ready <= 1'($urandom_range(0, 1));
                default: op_ready <= 1'b0;
            endcase
        end
    end

    // Scoreboard and in-flight monitor
    int max_infl = 0, infl_lim = 1, n_rd = 0;
    bit stall_viol = 1'b0;
    always @(negedge clk) begin
        if (rsn) begin
            if (run_hs - run_wr > max_infl) max_infl = run_hs - run_wr;
            if (vec_rd && (run_hs - run_wr >= infl_lim)) stall_viol = 1'b1;
            if (vec_rd) n_rd++;
            if (res_we) begin
                chk("res_addr", 128'(res_addr), 128'(run_wr));
                chk("res_wdata", 128'(res_wdata), 128'(expect_op(run_wr)));
                run_wr++;
            end
        end
    end

    task automatic run(input bit m, input int n, input int rdy, input int lat,
                       input bit lr, input bit mute);
        @(negedge clk);
        pq.delete();
        run_hs = 0; run_wr = 0; max_infl = 0; stall_viol = 1'b0; n_rd = 0;
        mdl_min = 65535; mdl_max = 0;
        infl_lim = m ? MO : 1;
        rdy_mode = rdy; fpu_lat = lat; lat_rand = lr; fpu_mute = mute;
        start = 1'b1; mode = m; num_ops = AW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", 128'(done), 128'(1));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctl"}, 128'({busy, done, tmo_flag, spurious, vec_rd, op_valid, res_we}), 128'(0));
        chk({tag, "_addr"}, 128'({vec_addr, res_addr, issued, retired}), 128'(0));
        chk({tag, "_data"}, 128'({op_src[127:0] | op_src[NS*ELEN-1 -: 128]}), 128'(0));
        chk({tag, "_wdata"}, 128'(res_wdata), 128'(0));
        chk({tag, "_max_lat"}, 128'(max_lat), 128'(0));
        chk({tag, "_min_lat"}, 128'(min_lat), 128'(16'hFFFF));
    endtask

    typedef struct {
        bit mode; int num; int rdy; int lat;
        int exp_max; int exp_min; int exp_peak;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NS*ELEN-1:0] held;
        bit                 stable;
        int                 wr_snap;
        int                 k;

        tbl[0] = '{1'b0,  3, 0,  4,  4,     4, 1};
        tbl[1] = '{1'b1, 16, 0, 10, 10,    10, 0};
        tbl[2] = '{1'b0,  5, 1,  1,  1,     1, 1};
        tbl[3] = '{1'b1,  9, 1,  2,  2,     2, 0};
        tbl[4] = '{1'b1,  7, 0, 20, 20,    20, 4};
        tbl[5] = '{1'b1,  0, 0,  4,  0, 65535, 0};
        for (int i = 0; i < (1<<AW); i++) mem[i] = {$urandom, $urandom};

        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rsn = 1'b1;
        repeat (2) @(negedge clk);

        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spurious_idle", 128'(spurious), 128'(1));
        chk("spurious_nowrite", 128'(run_wr), 128'(0));

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].mode, tbl[i].num, tbl[i].rdy, tbl[i].lat, 1'b0, 1'b0);
            if (tbl[i].num == 0) begin
                chk("zero_done_next", 128'({done, busy}), 128'(2'b10));
            end else begin
                chk("busy_after_start", 128'(busy), 128'(1));
            end
            wait_done(4000);
            chk("tbl_timeout", 128'(tmo_flag), 128'(0));
            chk("tbl_issued", 128'(issued), 128'(tbl[i].num));
            chk("tbl_retired", 128'(retired), 128'(tbl[i].num));
            chk("tbl_writes", 128'(run_wr), 128'(tbl[i].num));
            chk("tbl_reads", 128'(n_rd), 128'(NS * tbl[i].num));
            chk("tbl_max_lat", 128'(max_lat), 128'(tbl[i].exp_max));
            chk("tbl_min_lat", 128'(min_lat), 128'(tbl[i].exp_min));
            chk("tbl_credit", 128'({stall_viol, (max_infl > infl_lim)}), 128'(0));
            if (tbl[i].exp_peak != 0) chk("tbl_peak", 128'(max_infl), 128'(tbl[i].exp_peak));
            chk("tbl_spurious", 128'(spurious), 128'(0));
        end

        // Random per-op latency with random ready, pipelined
        run(1'b1, 12, 1, 0, 1'b1, 1'b0);
        wait_done(4000);
        chk("rnd_retired", 128'(retired), 128'(12));
        chk("rnd_writes", 128'(run_wr), 128'(12));
        chk("rnd_max_lat", 128'(max_lat), 128'(mdl_max));
        chk("rnd_min_lat", 128'(min_lat), 128'(mdl_min));
        chk("rnd_credit", 128'({stall_viol, (max_infl > MO)}), 128'(0));

        // Ready held low for 7 cycles while an op waits in ISSUE
        run(1'b0, 2, 2, 3, 1'b0, 1'b0);
        k = 0;
        while (!op_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("stall_issue_reached", 128'(op_valid), 128'(1));
        held = op_src;
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (op_src !== held || !op_valid) stable = 1'b0;
        end
        chk("stall_src_stable", 128'(stable), 128'(1));
        chk("stall_no_push", 128'(run_hs), 128'(0));
        rdy_mode = 0;
        wait_done(500);
        chk("stall_pushes", 128'(run_hs), 128'(2));
        chk("stall_writes", 128'(run_wr), 128'(2));
        chk("stall_lat", 128'({max_lat, min_lat}), 128'({16'd3, 16'd3}));

        // FPU never responds
        run(1'b0, 2, 0, 4, 1'b0, 1'b1);
        wait_done(TMO + 200);
        chk("tmo_flags", 128'({tmo_flag, done, busy}), 128'(3'b110));
        chk("tmo_elapsed_ok", 128'((cyc - last_evt >= TMO) && (cyc - last_evt <= TMO + 1)), 128'(1));
        chk("tmo_counts", 128'({issued, retired}), 128'({12'd1, 12'd0}));
        fpu_mute = 1'b0;
        repeat (10) @(negedge clk);
        chk("tmo_late_nowrite", 128'(run_wr), 128'(0));
        chk("tmo_still_err", 128'({tmo_flag, retired}), 128'({1'b1, 12'd0}));

        // Asynchronous reset in the middle of DRAIN
        run(1'b1, 8, 0, 30, 1'b0, 1'b0);
        k = 0;
        while (issued != 8 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("drain_reached", 128'(issued), 128'(8));
        chk("drain_pending", 128'(retired != 8), 128'(1));
        wr_snap = run_wr;
        #2 rsn = 1'b0;
        #1 check_reset_outs("mid_drain");
        repeat (3) @(negedge clk);
        rsn = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_nowrite", 128'(run_wr), 128'(wr_snap));
        chk("post_reset_idle", 128'({busy, done}), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
